// File: rtl/rank_pkg.sv
// Shared definitions for the rank-ordered PIFO: default field widths and the
// entry record (valid, queue, priority) used when viewing a slot as a unit.
package rank_pkg;

  localparam int PRIORITY_WIDTH_DEF    = 12;
  localparam int QUEUE_INDEX_WIDTH_DEF = 6;

  // One sorted slot at default widths; prio is named to avoid the SV keyword.
  typedef struct packed {
    logic                             valid;
    logic [QUEUE_INDEX_WIDTH_DEF-1:0] queue;
    logic [PRIORITY_WIDTH_DEF-1:0]    prio;
  } entry_t;

endpackage

// File: rtl/rank_pifo_cell.sv
// One slot of the PIFO shift array. Each slot decides locally whether to
// hold, take the new entry, take its left neighbour (push shifts right) or
// take its right neighbour (pop shifts left), using only its own and its
// neighbours' "new entry sorts after me" flags.
module rank_pifo_cell import rank_pkg::*; #(
  parameter int PRIORITY_WIDTH    = PRIORITY_WIDTH_DEF,
  parameter int QUEUE_INDEX_WIDTH = QUEUE_INDEX_WIDTH_DEF,
  parameter bit IS_HEAD           = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [QUEUE_INDEX_WIDTH-1:0] new_queue,
  input  logic [PRIORITY_WIDTH-1:0]    new_prio,
  input  logic                         left_valid,
  input  logic [QUEUE_INDEX_WIDTH-1:0] left_queue,
  input  logic [PRIORITY_WIDTH-1:0]    left_prio,
  input  logic                         left_go,
  input  logic                         right_valid,
  input  logic [QUEUE_INDEX_WIDTH-1:0] right_queue,
  input  logic [PRIORITY_WIDTH-1:0]    right_prio,
  input  logic                         right_go,
  output logic                         valid,
  output logic [QUEUE_INDEX_WIDTH-1:0] queue,
  output logic [PRIORITY_WIDTH-1:0]    prio,
  output logic                         go_after
);

  logic                         valid_q, valid_d;
  logic [QUEUE_INDEX_WIDTH-1:0] queue_q, queue_d;
  logic [PRIORITY_WIDTH-1:0]    prio_q, prio_d;

  // Ties use <= so a new entry lands behind every equal-rank entry.
  assign go_after = valid_q && (prio_q <= new_prio);

  // Select next slot contents from hold / new / left / right.
  always_comb begin
    valid_d = valid_q;
    queue_d = queue_q;
    prio_d  = prio_q;
    unique case ({push, pop})
      2'b10: begin
        if (go_after) begin
          valid_d = valid_q;
        end else if (IS_HEAD || left_go) begin
          valid_d = 1'b1;
          queue_d = new_queue;
          prio_d  = new_prio;
        end else begin
          valid_d = left_valid;
          queue_d = left_queue;
          prio_d  = left_prio;
        end
      end
      2'b01: begin
        valid_d = right_valid;
        queue_d = right_queue;
        prio_d  = right_prio;
      end
      2'b11: begin
        // Old head leaves; remaining entries shift left while the new entry
        // is placed in sorted position among them.
        if (right_go) begin
          valid_d = right_valid;
          queue_d = right_queue;
          prio_d  = right_prio;
        end else if (IS_HEAD || go_after) begin
          valid_d = 1'b1;
          queue_d = new_queue;
          prio_d  = new_prio;
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        valid_d = valid_q;
      end
    endcase
  end

  // Slot storage; empty slots always carry queue 0 and the least urgent rank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      queue_q <= '0;
      prio_q  <= '1;
    end else begin
      valid_q <= valid_d;
      queue_q <= queue_d;
      prio_q  <= prio_d;
    end
  end

  assign valid = valid_q;
  assign queue = queue_q;
  assign prio  = prio_q;

endmodule

// File: rtl/rank_pifo.sv
// Rank-ordered push-in/first-out queue built from a linear array of
// rank_pifo_cell slots kept sorted ascending by priority (slot 0 = head).
// Optional feature: define RANK_PIFO_STATS_EN to build the occupancy
// high-water mark; otherwise status_max_count is tied to zero.
module rank_pifo import rank_pkg::*; #(
  parameter int PIFO_DEPTH        = 16,
  parameter int PRIORITY_WIDTH    = PRIORITY_WIDTH_DEF,
  parameter int QUEUE_COUNT       = 64,
  parameter int QUEUE_INDEX_WIDTH = QUEUE_INDEX_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_doorbell_queue,
  input  logic [PRIORITY_WIDTH-1:0]    s_axis_doorbell_priority,
  input  logic                         s_axis_doorbell_valid,
  output logic                         s_axis_doorbell_ready,
  output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_sched_queue,
  output logic [PRIORITY_WIDTH-1:0]    m_axis_sched_priority,
  output logic                         m_axis_sched_valid,
  input  logic                         m_axis_sched_ready,
  output logic [QUEUE_COUNT-1:0]       pifo_pop_signal,
  output logic [$clog2(PIFO_DEPTH):0]  status_count,
  output logic [$clog2(PIFO_DEPTH):0]  status_max_count
);

  localparam int CW = $clog2(PIFO_DEPTH) + 1;

  logic                         slot_valid [PIFO_DEPTH];
  logic [QUEUE_INDEX_WIDTH-1:0] slot_queue [PIFO_DEPTH];
  logic [PRIORITY_WIDTH-1:0]    slot_prio  [PIFO_DEPTH];
  logic                         slot_go    [PIFO_DEPTH];

  logic                   push, pop;
  logic [CW-1:0]          count_q, count_d;
  logic                   ready_q, ready_d;
  logic [QUEUE_COUNT-1:0] pop_sig_q, pop_sig_d;

  assign push = s_axis_doorbell_valid && ready_q;
  assign pop  = slot_valid[0] && m_axis_sched_ready;

  for (genvar i = 0; i < PIFO_DEPTH; i++) begin : g_slot
    logic                         l_valid, r_valid, l_go, r_go;
    logic [QUEUE_INDEX_WIDTH-1:0] l_queue, r_queue;
    logic [PRIORITY_WIDTH-1:0]    l_prio, r_prio;

    if (i == 0) begin : g_left_edge
      assign l_valid = 1'b0;
      assign l_queue = '0;
      assign l_prio  = '1;
      assign l_go    = 1'b1;
    end else begin : g_left
      assign l_valid = slot_valid[i-1];
      assign l_queue = slot_queue[i-1];
      assign l_prio  = slot_prio[i-1];
      assign l_go    = slot_go[i-1];
    end

    if (i == PIFO_DEPTH - 1) begin : g_right_edge
      assign r_valid = 1'b0;
      assign r_queue = '0;
      assign r_prio  = '1;
      assign r_go    = 1'b0;
    end else begin : g_right
      assign r_valid = slot_valid[i+1];
      assign r_queue = slot_queue[i+1];
      assign r_prio  = slot_prio[i+1];
      assign r_go    = slot_go[i+1];
    end

    rank_pifo_cell #(
      .PRIORITY_WIDTH    (PRIORITY_WIDTH),
      .QUEUE_INDEX_WIDTH (QUEUE_INDEX_WIDTH),
      .IS_HEAD           (i == 0)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .pop         (pop),
      .new_queue   (s_axis_doorbell_queue),
      .new_prio    (s_axis_doorbell_priority),
      .left_valid  (l_valid),
      .left_queue  (l_queue),
      .left_prio   (l_prio),
      .left_go     (l_go),
      .right_valid (r_valid),
      .right_queue (r_queue),
      .right_prio  (r_prio),
      .right_go    (r_go),
      .valid       (slot_valid[i]),
      .queue       (slot_queue[i]),
      .prio        (slot_prio[i]),
      .go_after    (slot_go[i])
    );
  end

  // Occupancy, registered ready and per-queue dequeue toggles.
  always_comb begin
    count_d   = count_q + CW'(push) - CW'(pop);
    ready_d   = count_d < CW'(PIFO_DEPTH);
    pop_sig_d = pop_sig_q;
    if (pop) begin
      pop_sig_d = pop_sig_q ^ (QUEUE_COUNT'(1) << slot_queue[0]);
    end
  end

  // Control state; ready rises on the first edge after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      ready_q   <= 1'b0;
      pop_sig_q <= '0;
    end else begin
      count_q   <= count_d;
      ready_q   <= ready_d;
      pop_sig_q <= pop_sig_d;
    end
  end

`ifdef RANK_PIFO_STATS_EN
  logic [CW-1:0] max_q, max_d;

  // High-water mark trails the occupancy by one cycle.
  always_comb begin
    max_d = (count_q > max_q) ? count_q : max_q;
  end

  // High-water mark register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign status_max_count = max_q;
`else
  assign status_max_count = '0;
`endif

  assign s_axis_doorbell_ready = ready_q;
  assign m_axis_sched_valid    = slot_valid[0];
  assign m_axis_sched_queue    = slot_queue[0];
  assign m_axis_sched_priority = slot_prio[0];
  assign pifo_pop_signal       = pop_sig_q;
  assign status_count          = count_q;

endmodule

// File: tb/tb_rank_pifo.sv
// Directed bench for rank_pifo: queue-based reference model checked every
// cycle, plus hand-computed literal expectations for key scenarios.
module tb_rank_pifo;
  import rank_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  s_q = '0;
  logic [11:0] s_p = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [5:0]  m_q;
  logic [11:0] m_p;
  logic        m_valid;
  logic        m_rdy = 1'b0;
  logic [63:0] pop_sig;
  logic [4:0]  cnt;
  logic [4:0]  max_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  rank_pifo dut (
    .clk                      (clk),
    .rst                      (rst),
    .s_axis_doorbell_queue    (s_q),
    .s_axis_doorbell_priority (s_p),
    .s_axis_doorbell_valid    (s_valid),
    .s_axis_doorbell_ready    (s_ready),
    .m_axis_sched_queue       (m_q),
    .m_axis_sched_priority    (m_p),
    .m_axis_sched_valid       (m_valid),
    .m_axis_sched_ready       (m_rdy),
    .pifo_pop_signal          (pop_sig),
    .status_count             (cnt),
    .status_max_count         (max_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a sorted list of entries.
  entry_t      mq[$];
  logic        m_ready_m = 1'b0;
  logic [63:0] m_pop_sig = '0;
  int          m_max = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ready_m = 1'b0;
      m_pop_sig = '0;
      m_max     = 0;
    end else begin
      bit     do_pop, do_push;
      entry_t e;
      int     k;
      do_pop  = (mq.size() != 0) && m_rdy;
      do_push = s_valid && m_ready_m;
`ifdef RANK_PIFO_STATS_EN
      if (mq.size() > m_max) m_max = mq.size();
`endif
      if (do_pop) begin
        m_pop_sig[mq[0].queue] = ~m_pop_sig[mq[0].queue];
        void'(mq.pop_front());
      end
      if (do_push) begin
        e.valid = 1'b1;
        e.queue = s_q;
        e.prio  = s_p;
        k = 0;
        while (k < mq.size() && mq[k].prio <= s_p) k++;
        mq.insert(k, e);
      end
      m_ready_m = (mq.size() < DEPTH);
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    chk("m_valid", {63'd0, m_valid}, {63'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("m_queue", {58'd0, m_q}, {58'd0, mq[0].queue});
      chk("m_prio", {52'd0, m_p}, {52'd0, mq[0].prio});
    end
    chk("count", {59'd0, cnt}, 64'(mq.size()));
    chk("ready", {63'd0, s_ready}, {63'd0, m_ready_m});
    chk("pop_sig", pop_sig, m_pop_sig);
    chk("max_count", {59'd0, max_cnt}, 64'(m_max));
  end

  // One clock of stimulus starting from a falling edge.
  task automatic cyc(input bit v, input int q, input int p, input bit r);
    s_valid = v;
    s_q     = q[5:0];
    s_p     = p[11:0];
    m_rdy   = r;
    @(negedge clk);
    s_valid = 1'b0;
    m_rdy   = 1'b0;
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_valid"}, {63'd0, m_valid}, 64'd0);
    chk({tag, "_queue"}, {58'd0, m_q}, 64'd0);
    chk({tag, "_prio"}, {52'd0, m_p}, 64'hFFF);
    chk({tag, "_ready"}, {63'd0, s_ready}, 64'd0);
    chk({tag, "_count"}, {59'd0, cnt}, 64'd0);
    chk({tag, "_max"}, {59'd0, max_cnt}, 64'd0);
    chk({tag, "_popsig"}, pop_sig, 64'd0);
  endtask

  // Mid-cycle asynchronous reset pulse followed by release.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1 reset_literals(tag);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_after"}, {63'd0, s_ready}, 64'd1);
  endtask

  initial begin
    // Power-on reset
    @(negedge clk);
    reset_literals("por");
    rst = 1'b0;
    @(negedge clk);
    chk("por_ready_after", {63'd0, s_ready}, 64'd1);

    // Sorted order and per-queue toggles
    cyc(1, 3, 50, 0);
    cyc(1, 7, 10, 0);
    cyc(1, 1, 30, 0);
    chk("sort_head0", {58'd0, m_q}, 64'd7);
    cyc(0, 0, 0, 1);
    chk("sort_head1", {58'd0, m_q}, 64'd1);
    cyc(0, 0, 0, 1);
    chk("sort_head2", {58'd0, m_q}, 64'd3);
    cyc(0, 0, 0, 1);
    chk("sort_popsig", pop_sig, 64'h8A);
    chk("sort_empty", {63'd0, m_valid}, 64'd0);

    // FIFO among equal ranks
    cyc(1, 2, 20, 0);
    cyc(1, 5, 20, 0);
    chk("tie_head0", {58'd0, m_q}, 64'd2);
    cyc(0, 0, 0, 1);
    chk("tie_head1", {58'd0, m_q}, 64'd5);
    cyc(0, 0, 0, 1);

    // Fill to capacity, then push with concurrent pop
    for (int i = 0; i < DEPTH; i++) cyc(1, i, ((i * 7) % 16) * 10, 0);
    chk("full_ready", {63'd0, s_ready}, 64'd0);
    chk("full_count", {59'd0, cnt}, 64'd16);
    chk("full_head", {52'd0, m_p}, 64'd0);
    cyc(1, 9, 0, 1);
    chk("full_pp_count", {59'd0, cnt}, 64'd15);
    chk("full_pp_ready", {63'd0, s_ready}, 64'd1);
    chk("full_pp_head", {52'd0, m_p}, 64'd10);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1);
    chk("full_drained", {59'd0, cnt}, 64'd0);

    // Simultaneous push and pop with a new most-urgent entry
    cyc(1, 0, 40, 0);
    cyc(1, 1, 50, 0);
    cyc(1, 2, 60, 0);
    cyc(1, 3, 70, 0);
    cyc(1, 9, 5, 1);
    chk("pp_count", {59'd0, cnt}, 64'd4);
    chk("pp_head_q", {58'd0, m_q}, 64'd9);
    chk("pp_head_p", {52'd0, m_p}, 64'd5);
    cyc(0, 0, 0, 1);
    chk("pp_next_p", {52'd0, m_p}, 64'd50);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

    // Reset with entries present
    pulse_reset("rst_a");
    for (int i = 0; i < 8; i++) cyc(1, i + 10, i * 5, 0);
    cyc(0, 0, 0, 0);
    chk("pre_rst_count", {59'd0, cnt}, 64'd8);
`ifdef RANK_PIFO_STATS_EN
    chk("pre_rst_max", {59'd0, max_cnt}, 64'd8);
`else
    chk("pre_rst_max", {59'd0, max_cnt}, 64'd0);
`endif
    pulse_reset("rst_b");

    // Dequeue requests while empty
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    chk("empty_popsig", pop_sig, 64'd0);
    chk("empty_count", {59'd0, cnt}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rank_pifo.md
RANK_PIFO -- requirements
Module: rank_pifo

Interface
REQ-001 SHALL have parameter PIFO_DEPTH, default 16, number of sorted entry slots (power of 2, 2..64).
REQ-002 SHALL have parameter PRIORITY_WIDTH, default 12, rank width; a lower value is more urgent.
REQ-003 SHALL have parameter QUEUE_COUNT, default 64, number of queues tracked by pop-toggle bits.
REQ-004 SHALL have parameter QUEUE_INDEX_WIDTH, default 6, queue index width (= log2 QUEUE_COUNT).
REQ-005 SHALL use one clock; reset is asynchronous and active-high: clk  input  1  clock; rst  input  1  async active-high reset.
REQ-006 SHALL have s_axis_doorbell_queue  input  QUEUE_INDEX_WIDTH  queue of incoming rank.
REQ-007 SHALL have s_axis_doorbell_priority  input  PRIORITY_WIDTH  incoming rank.
REQ-008 SHALL have s_axis_doorbell_valid  input  1  incoming entry valid.
REQ-009 SHALL have s_axis_doorbell_ready  output  1  entry accepted this cycle when high with valid.
REQ-010 SHALL have m_axis_sched_queue  output  QUEUE_INDEX_WIDTH  head entry queue.
REQ-011 SHALL have m_axis_sched_priority  output  PRIORITY_WIDTH  head entry rank.
REQ-012 SHALL have m_axis_sched_valid  output  1  head entry present.
REQ-013 SHALL have m_axis_sched_ready  input  1  scheduler dequeues head.
REQ-014 SHALL have pifo_pop_signal  output  QUEUE_COUNT  per-queue toggle bit, flips once per dequeue of that queue.
REQ-015 SHALL have status_count  output  log2(PIFO_DEPTH)+1  current occupancy.
REQ-016 SHALL have status_max_count  output  log2(PIFO_DEPTH)+1  occupancy high-water mark.

Function
REQ-017 SHALL hold entries in slots 0..PIFO_DEPTH-1 sorted ascending by priority, slot 0 = head.
REQ-018 SHALL insert equal-priority entries behind all existing equal entries (FIFO among ties).
REQ-019 SHALL accept a push when s_axis_doorbell_valid && s_axis_doorbell_ready at the clock edge.
REQ-020 SHALL drive s_axis_doorbell_ready from a register, high iff status_count < PIFO_DEPTH; a simultaneous pop does not make a full PIFO ready.
REQ-021 SHALL make a pushed entry visible at m_axis_sched_* on the cycle after acceptance (latency 1).
REQ-022 SHALL drive m_axis_sched_valid = (status_count != 0) and m_axis_sched_queue/priority = slot 0 contents, registered.
REQ-023 SHALL dequeue when m_axis_sched_valid && m_axis_sched_ready, shifting all slots toward slot 0 by one.
REQ-024 SHALL, on simultaneous push and pop, remove the old head and insert the new entry in sorted position among remaining entries in the same cycle; status_count unchanged.
REQ-025 SHALL, if the pushed entry is strictly more urgent than every remaining entry during simultaneous push/pop, present it as head the next cycle.
REQ-026 SHALL toggle pifo_pop_signal[q] one cycle after dequeue of an entry with queue q; all other bits hold.
REQ-027 SHALL ignore m_axis_sched_ready while empty (no toggle, no count change).
REQ-028 SHALL update status_max_count to max(status_max_count, status_count) each cycle.

Reset
REQ-029 SHALL on rst assertion immediately clear all slots, status_count=0, status_max_count=0, pifo_pop_signal=0, m_axis_sched_valid=0, m_axis_sched_queue=0, m_axis_sched_priority=all ones, s_axis_doorbell_ready=0.
REQ-030 SHALL raise s_axis_doorbell_ready on the first clock edge after rst deasserts; entries in flight during reset are discarded.

Configuration
REQ-031 SHALL compile status_max_count logic only when RANK_PIFO_STATS_EN is defined; without it status_max_count SHALL be constant 0 and the port retained.

Structure
REQ-032 SHALL place PRIORITY_WIDTH, QUEUE_INDEX_WIDTH defaults and the entry struct (valid, queue, priority) in shared package rank_pkg.
REQ-033 SHALL implement one slot as sub-module rank_pifo_cell (compare, hold, shift-in-from-left, shift-from-right) instantiated PIFO_DEPTH times.

Verification
REQ-034 SHALL cover: push (q3,p50),(q7,p10),(q1,p30) -> pops return q7,q1,q3; pifo_pop_signal bits 7,1,3 each toggle once.
REQ-035 SHALL cover: push (q2,p20) then (q5,p20) -> pops return q2 then q5.
REQ-036 SHALL cover: fill 16 entries -> ready low, status_count=16; push with concurrent pop -> no accept; next cycle ready high.
REQ-037 SHALL cover: 4 entries p40..p70, simultaneous push (q9,p5) and pop -> count stays 4, next head q9 p5.
REQ-038 SHALL cover: 8 entries then rst pulse mid-cycle -> all outputs at reset values immediately; status_max_count=0 (8 before reset when RANK_PIFO_STATS_EN defined).
REQ-039 SHALL cover: ready held high while empty -> pifo_pop_signal stays 0, status_count stays 0.
